// File: rtl/pcie_merge.sv
// pcie_merge_fifo: generic circular FIFO with synchronous clear; head is the oldest word.
// Latency: a word written at edge N is visible at head after edge N.
// Backpressure: none internally; the caller must gate push/pop using count.
module pcie_merge_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers and occupancy; reset and clear both empty the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage array; contents are don't-care while count says the slot is empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// pcie_merge: merges two 6-bit word streams (D0/D1) into one output queue, round-robin.
// Latency: push->eligible 1 edge, transfer 1 edge, pop->data_out 1 edge (registered).
// Backpressure: pausa0/1 raised at the programmable threshold; overflow/underflow go to sticky ERROR.
module pcie_merge (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [1:0] umbral_alto,
  input  logic [5:0] data_in0,
  input  logic [5:0] data_in1,
  input  logic       push0,
  input  logic       push1,
  input  logic       pop,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic       pausa0,
  output logic       pausa1,
  output logic       empty_out,
  output logic       idle_out,
  output logic       active_out,
  output logic       error_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] umbral_q;
  logic       last_grant;   // 1 = D1 was granted last

  logic [2:0] cnt0, cnt1;
  logic [3:0] cnto;
  logic [5:0] head0, head1, heado;

  logic       op, clr;
  logic       wr0, wr1, err0, err1;
  logic       pop_ok, pop_err;
  logic       ne0, ne1, grant1, xfer, rd0, rd1;
  logic [2:0] n0, n1, n0_eff, n1_eff, thr;
  logic [3:0] no;
  logic       any_nz, err_evt;

  // Only IDLE and ACTIVE act on push/pop; INIT empties every queue.
  assign op  = (state == S_IDLE) || (state == S_ACTIVE);
  assign clr = (state == S_INIT);

  // Push and pop qualification is against the count at cycle start.
  assign wr0     = op && push0 && (cnt0 != 3'd4);
  assign wr1     = op && push1 && (cnt1 != 3'd4);
  assign err0    = op && push0 && (cnt0 == 3'd4);
  assign err1    = op && push1 && (cnt1 == 3'd4);
  assign pop_ok  = op && pop && (cnto != 4'd0);
  assign pop_err = op && pop && (cnto == 4'd0);
  assign err_evt = err0 || err1 || pop_err;

  // Round-robin: a lone non-empty source wins; on a tie the one not granted last wins.
  assign ne0    = (cnt0 != 3'd0);
  assign ne1    = (cnt1 != 3'd0);
  assign grant1 = ne1 && (!ne0 || !last_grant);
  // A full output queue still accepts a word when a pop frees the head this cycle.
  assign xfer   = op && (ne0 || ne1) && ((cnto != 4'd8) || pop);
  assign rd0    = xfer && !grant1;
  assign rd1    = xfer && grant1;

  // Post-update occupancies drive next state and the pause flags.
  assign n0     = cnt0 + {2'b00, wr0} - {2'b00, rd0};
  assign n1     = cnt1 + {2'b00, wr1} - {2'b00, rd1};
  assign no     = cnto + {3'b000, xfer} - {3'b000, pop_ok};
  assign n0_eff = clr ? 3'd0 : n0;
  assign n1_eff = clr ? 3'd0 : n1;
  assign any_nz = (n0 != 3'd0) || (n1 != 3'd0) || (no != 4'd0);
  assign thr    = (umbral_q == 2'd0) ? 3'd4 : {1'b0, umbral_q};

  assign empty_out = (cnto == 4'd0);

  pcie_merge_fifo #(.W(6), .DEPTH(4), .AW(2)) u_fifo0 (
    .clk(clk), .reset(reset), .clr(clr), .push(wr0), .pop(rd0),
    .din(data_in0), .head(head0), .count(cnt0)
  );

  pcie_merge_fifo #(.W(6), .DEPTH(4), .AW(2)) u_fifo1 (
    .clk(clk), .reset(reset), .clr(clr), .push(wr1), .pop(rd1),
    .din(data_in1), .head(head1), .count(cnt1)
  );

  pcie_merge_fifo #(.W(6), .DEPTH(8), .AW(3)) u_fifoo (
    .clk(clk), .reset(reset), .clr(clr), .push(xfer), .pop(pop_ok),
    .din(grant1 ? head1 : head0), .head(heado), .count(cnto)
  );

  // Next-state selection; ERROR is left only through init or reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = init ? S_INIT : S_RESET;
      S_INIT:   state_nxt = init ? S_INIT : S_IDLE;
      S_IDLE,
      S_ACTIVE: begin
        if (err_evt)     state_nxt = S_ERROR;
        else if (any_nz) state_nxt = S_ACTIVE;
        else             state_nxt = S_IDLE;
      end
      S_ERROR:  state_nxt = init ? S_INIT : S_ERROR;
      default:  state_nxt = S_RESET;
    endcase
  end

  // State register plus all registered outputs, configuration and arbiter memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RESET;
      data_out   <= 6'd0;
      valid_out  <= 1'b0;
      pausa0     <= 1'b0;
      pausa1     <= 1'b0;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      umbral_q   <= 2'd3;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      idle_out   <= (state_nxt == S_IDLE);
      active_out <= (state_nxt == S_ACTIVE);
      error_out  <= (state_nxt == S_ERROR);
      valid_out  <= pop_ok;
      if (pop_ok) data_out <= heado;
      if (xfer)   last_grant <= grant1;
      if (clr)    umbral_q <= umbral_alto;
      pausa0     <= (n0_eff >= thr);
      pausa1     <= (n1_eff >= thr);
    end
  end

endmodule

// File: tb/tb_pcie_merge.sv
// Directed bench for pcie_merge: a per-cycle vector table plus hand sequences
// for back-pressure/overflow, underflow and asynchronous reset mid-operation.
module tb_pcie_merge;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [1:0] umbral_alto;
  logic [5:0] data_in0, data_in1;
  logic       push0, push1, pop;
  logic [5:0] data_out;
  logic       valid_out, pausa0, pausa1, empty_out, idle_out, active_out, error_out;

  int total = 0;
  int bad   = 0;

  pcie_merge dut (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto),
    .data_in0(data_in0), .data_in1(data_in1), .push0(push0), .push1(push1),
    .pop(pop), .data_out(data_out), .valid_out(valid_out), .pausa0(pausa0),
    .pausa1(pausa1), .empty_out(empty_out), .idle_out(idle_out),
    .active_out(active_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ini;
    logic [1:0] umb;
    logic       p0;
    logic [5:0] d0;
    logic       p1;
    logic [5:0] d1;
    logic       pp;
    logic [5:0] e_dout;
    logic       e_vld;
    logic       e_pa0;
    logic       e_pa1;
    logic       e_emp;
    logic       e_idle;
    logic       e_act;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] dout, input logic v,
                         input logic p0e, input logic p1e, input logic em,
                         input logic id, input logic ac, input logic er);
    chk({tag, ".data_out"},   data_out, dout);
    chk({tag, ".valid_out"},  {5'd0, valid_out},  {5'd0, v});
    chk({tag, ".pausa0"},     {5'd0, pausa0},     {5'd0, p0e});
    chk({tag, ".pausa1"},     {5'd0, pausa1},     {5'd0, p1e});
    chk({tag, ".empty_out"},  {5'd0, empty_out},  {5'd0, em});
    chk({tag, ".idle_out"},   {5'd0, idle_out},   {5'd0, id});
    chk({tag, ".active_out"}, {5'd0, active_out}, {5'd0, ac});
    chk({tag, ".error_out"},  {5'd0, error_out},  {5'd0, er});
  endtask

  // One clock: inputs are driven at a negedge, outputs sampled at the next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    init = 1'b0; push0 = 1'b0; push1 = 1'b0; pop = 1'b0;
    data_in0 = 6'd0; data_in1 = 6'd0;
  endtask

  task automatic restart(input logic [1:0] umb);
    clear_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    init = 1'b1; umbral_alto = umb;
    cyc();
    init = 1'b0;
    cyc();
  endtask

  initial begin
    vec_t t;
    clear_inputs();
    reset = 1'b1;
    umbral_alto = 2'd0;
    #2;
    chk_all("reset0", 6'd0, 0, 0, 0, 1, 0, 0, 0);

    //          rst ini umb p0  d0         p1  d1         pp  dout       v  pa0 pa1 emp idl act err
    tbl.push_back('{1, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 1, 6'b011011, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 1, 6'b011011, 1, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b011011, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 1, 6'b000011, 1, 6'b101101, 0, 6'b000000, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 1, 6'b011010, 1, 6'b101011, 0, 6'b000000, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 1, 6'b000011, 1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 1, 6'b101101, 1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 1, 6'b011010, 1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 1, 6'b101011, 1, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 6'b000000, 0, 6'b000000, 0, 6'b101011, 0, 0, 0, 1, 1, 0, 0});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      reset = t.rst; init = t.ini; umbral_alto = t.umb;
      push0 = t.p0; data_in0 = t.d0; push1 = t.p1; data_in1 = t.d1; pop = t.pp;
      cyc();
      chk_all($sformatf("vec%0d", i), t.e_dout, t.e_vld, t.e_pa0, t.e_pa1,
              t.e_emp, t.e_idle, t.e_act, t.e_err);
    end

    // Fill: output queue absorbs 8, D0 then backs up to 4; threshold 2.
    restart(2'd2);
    chk("fill.start_idle", {5'd0, idle_out}, 6'd1);
    for (int k = 1; k <= 12; k++) begin
      push0 = 1'b1; data_in0 = 6'(k);
      cyc();
      chk($sformatf("fill%0d.pausa0", k), {5'd0, pausa0}, {5'd0, (k >= 10)});
      chk($sformatf("fill%0d.empty", k), {5'd0, empty_out}, {5'd0, (k == 1)});
      chk($sformatf("fill%0d.active", k), {5'd0, active_out}, 6'd1);
    end
    data_in0 = 6'h3F;
    cyc();
    push0 = 1'b0;
    chk("overflow.error", {5'd0, error_out}, 6'd1);
    chk("overflow.active", {5'd0, active_out}, 6'd0);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("err_pop.valid", {5'd0, valid_out}, 6'd0);
    chk("err_pop.data", data_out, 6'd0);
    chk("err_pop.sticky", {5'd0, error_out}, 6'd1);
    chk("err_pop.pausa0", {5'd0, pausa0}, 6'd1);
    chk("err_pop.empty", {5'd0, empty_out}, 6'd0);

    // Underflow straight after INIT, then recovery through INIT.
    restart(2'd3);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("under.error", {5'd0, error_out}, 6'd1);
    chk("under.valid", {5'd0, valid_out}, 6'd0);
    chk("under.data", data_out, 6'd0);
    chk("under.idle", {5'd0, idle_out}, 6'd0);
    cyc();
    chk("under.sticky", {5'd0, error_out}, 6'd1);
    init = 1'b1;
    cyc();
    chk("under.init_err", {5'd0, error_out}, 6'd0);
    chk("under.init_idle", {5'd0, idle_out}, 6'd0);
    init = 1'b0;
    cyc();
    chk("under.back_idle", {5'd0, idle_out}, 6'd1);

    // Asynchronous reset with words queued.
    restart(2'd2);
    push0 = 1'b1; data_in0 = 6'h15; cyc();
    data_in0 = 6'h2A; cyc();
    data_in0 = 6'h07; cyc();
    push0 = 1'b0; pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("arst.pre_data", data_out, 6'h15);
    chk("arst.pre_valid", {5'd0, valid_out}, 6'd1);
    chk("arst.pre_empty", {5'd0, empty_out}, 6'd0);
    #2 reset = 1'b1;
    #1;
    chk_all("arst.mid", 6'd0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    init = 1'b1;
    cyc();
    init = 1'b0;
    cyc();
    chk("arst.empty_after", {5'd0, empty_out}, 6'd1);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("arst.stale_error", {5'd0, error_out}, 6'd1);
    chk("arst.stale_valid", {5'd0, valid_out}, 6'd0);
    chk("arst.stale_data", data_out, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
